// File: rtl/calc1_port_responder_if.sv
// Request/response bundle for the calc1 command/data port.
// Bit 0 is the MSB on every vector, matching the legacy bench wiring.
interface calc1_port_responder_if;
    logic [0:3]  cmd_in;
    logic [0:31] data_in;
    logic [0:1]  out_resp;
    logic [0:31] data_out;
    logic        busy;

    modport master (
        output cmd_in,
        output data_in,
        input  out_resp,
        input  data_out,
        input  busy
    );

    modport slave (
        input  cmd_in,
        input  data_in,
        output out_resp,
        output data_out,
        output busy
    );
endinterface

// File: rtl/calc1_port_responder.sv
// calc1 single-port responder: command + operand 1, then operand 2, then a
// registered 2-bit response and 32-bit result after EXEC_CYCLES cycles.
module calc1_port_responder #(
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic                    c_clk,
    input  logic                    reset_n,
    calc1_port_responder_if.slave   port
);

    typedef enum logic [1:0] {
        IDLE,
        OP2,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [0:3]  cmd_q;
    logic [0:31] op1;
    logic [0:31] op2;

    logic [32:0] sum;
    logic [4:0]  shamt;
    logic [1:0]  res_code;
    logic [31:0] res_data;

    always_comb begin
        sum      = {1'b0, op1} + {1'b0, op2};
        shamt    = op2[27:31];
        res_code = 2'd3;
        res_data = '0;
        case (cmd_q)
            4'd1: begin
                if (sum[32]) begin
                    res_code = 2'd2;
                end else begin
                    res_code = 2'd1;
                    res_data = sum[31:0];
                end
            end
            4'd2: begin
                if (op1 < op2) begin
                    res_code = 2'd2;
                end else begin
                    res_code = 2'd1;
                    res_data = op1 - op2;
                end
            end
            4'd5: begin
                res_code = 2'd1;
                res_data = op1 << shamt;
            end
            4'd6: begin
                res_code = 2'd1;
                res_data = op1 >> shamt;
            end
            default: begin
                res_code = 2'd3;
                res_data = '0;
            end
        endcase
    end

    // Commands arriving outside IDLE (including on the RESP exit edge) are dropped.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_q         <= '0;
            op1           <= '0;
            op2           <= '0;
            port.out_resp <= '0;
            port.data_out <= '0;
            port.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (port.cmd_in != 4'd0) begin
                        cmd_q     <= port.cmd_in;
                        op1       <= port.data_in;
                        port.busy <= 1'b1;
                        state     <= OP2;
                    end
                end
                OP2: begin
                    op2   <= port.data_in;
                    cnt   <= 4'(EXEC_CYCLES - 1);
                    state <= EXEC;
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        port.out_resp <= res_code;
                        port.data_out <= res_data;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    port.out_resp <= '0;
                    port.data_out <= '0;
                    port.busy     <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder with hand-computed expected results.
module tb_calc1_port_responder;

    localparam int unsigned EXEC = 2;

    logic c_clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    calc1_port_responder_if bus ();

    calc1_port_responder #(
        .EXEC_CYCLES (EXEC)
    ) dut (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .port    (bus.slave)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(posedge c_clk);
            #1;
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Drives one request and checks the whole response window cycle by cycle.
    task automatic do_req(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data);
        wait_idle();
        @(negedge c_clk);
        bus.cmd_in  = cmd;
        bus.data_in = a;
        @(posedge c_clk);               // E0
        #1;
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        bus.cmd_in  = 4'd0;
        bus.data_in = b;
        @(posedge c_clk);               // E1
        #1;
        bus.data_in = '0;
        for (int unsigned k = 0; k + 1 < EXEC; k++) begin
            @(posedge c_clk);
            #1;
            check({tag, "_early"}, 32'(bus.out_resp), 32'd0);
        end
        @(posedge c_clk);               // E(1+EXEC)
        #1;
        check({tag, "_resp"}, 32'(bus.out_resp), 32'(exp_resp));
        check({tag, "_data"}, bus.data_out, exp_data);
        @(posedge c_clk);               // E(2+EXEC)
        #1;
        check({tag, "_resp_clr"}, 32'(bus.out_resp), 32'd0);
        check({tag, "_data_clr"}, bus.data_out, 32'd0);
        check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        bus.cmd_in   = '0;
        bus.data_in  = '0;
        #1;
        check("rst_resp", 32'(bus.out_resp), 32'd0);
        check("rst_data", bus.data_out, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge c_clk);
        @(negedge c_clk);
        reset_n = 1'b1;

        do_req("add_basic", 4'd1, 32'h0000_0001, 32'h0000_0002, 2'd1, 32'h0000_0003);

        for (int unsigned i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = 32'd1 << i;
            do_req("add_walk", 4'd1, v, 32'd0, 2'd1, v);
        end
        do_req("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0);
        do_req("add_max", 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF);

        do_req("sub_ok", 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
        do_req("sub_unf", 4'd2, 32'd5, 32'd7, 2'd2, 32'd0);
        do_req("sub_eq", 4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'd0);
        do_req("shl_31", 4'd5, 32'h0000_0001, 32'd31, 2'd1, 32'h8000_0000);
        do_req("shr_mask", 4'd6, 32'h8000_0000, 32'h0000_0025, 2'd1, 32'h0400_0000);
        do_req("shl_zero", 4'd5, 32'hA5A5_0F0F, 32'h0000_0020, 2'd1, 32'hA5A5_0F0F);
        do_req("shr_zero", 4'd6, 32'hDEAD_BEEF, 32'd0, 2'd1, 32'hDEAD_BEEF);
        do_req("inv_3", 4'd3, 32'h1111_1111, 32'h2222_2222, 2'd3, 32'd0);
        do_req("inv_15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 32'd0);

        // No-op held: nothing should start.
        @(negedge c_clk);
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'hFFFF_FFFF;
        for (int unsigned k = 0; k < 10; k++) begin
            @(posedge c_clk);
            #1;
            check("noop_busy", 32'(bus.busy), 32'd0);
            check("noop_resp", 32'(bus.out_resp), 32'd0);
        end
        bus.data_in = '0;

        // Busy drop: a subtract presented during EXEC must be ignored.
        @(negedge c_clk);
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd1;
        @(posedge c_clk);               // E0
        #1;
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'd2;
        @(posedge c_clk);               // E1
        #1;
        bus.cmd_in  = 4'd2;
        bus.data_in = 32'hFFFF_FFFF;
        @(posedge c_clk);               // E2
        #1;
        check("drop_early", 32'(bus.out_resp), 32'd0);
        @(posedge c_clk);               // E3
        #1;
        bus.cmd_in  = 4'd0;
        bus.data_in = '0;
        check("drop_resp", 32'(bus.out_resp), 32'd1);
        check("drop_data", bus.data_out, 32'd3);
        for (int unsigned k = 0; k < 10; k++) begin
            @(posedge c_clk);
            #1;
            check("drop_no_second", 32'(bus.out_resp), 32'd0);
            check("drop_busy", 32'(bus.busy), 32'd0);
        end

        // Reset in EXEC discards the request.
        @(negedge c_clk);
        bus.cmd_in  = 4'd1;
        bus.data_in = 32'd5;
        @(posedge c_clk);               // E0
        #1;
        bus.cmd_in  = 4'd0;
        bus.data_in = 32'd6;
        @(posedge c_clk);               // E1
        #1;
        bus.data_in = '0;
        @(posedge c_clk);               // E2, in EXEC
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_resp", 32'(bus.out_resp), 32'd0);
        check("midrst_data", bus.data_out, 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        reset_n = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            @(posedge c_clk);
            #1;
            check("midrst_no_resp", 32'(bus.out_resp), 32'd0);
            check("midrst_idle", 32'(bus.busy), 32'd0);
        end
        do_req("add_after_rst", 4'd1, 32'd10, 32'd20, 2'd1, 32'd30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
